// File: rtl/command_register_pkg.sv
// Shared definitions for the command register: word geometry, field
// positions inside the assembled 29-bit command, holding-register layout
// and the assembly FSM states.
package g15_pkg;

  localparam int WORD_BITS = 29;

  // Bit positions within the assembled word; index 0 is drum bit 1 (T1).
  localparam int CMD_DP_BIT = 0;
  localparam int CMD_D_LSB  = 1;
  localparam int CMD_D_MSB  = 5;
  localparam int CMD_S_LSB  = 6;
  localparam int CMD_S_MSB  = 10;
  localparam int CMD_C_LSB  = 11;
  localparam int CMD_C_MSB  = 12;
  localparam int CMD_N_LSB  = 13;
  localparam int CMD_N_MSB  = 19;
  localparam int CMD_BP_BIT = 20;
  localparam int CMD_T_LSB  = 21;
  localparam int CMD_T_MSB  = 27;
  localparam int CMD_ID_BIT = 28;

  // Number of bits held in the shift register before the final bit arrives.
  localparam int SHIFT_BITS = WORD_BITS - 1;

  // Declared MSB first so a cast from the raw word lands each field on
  // the bit positions listed above.
  typedef struct packed {
    logic       id;
    logic [6:0] t;
    logic       bp;
    logic [6:0] n;
    logic [1:0] c;
    logic [4:0] s;
    logic [4:0] d;
    logic       dp;
  } cmd_word_t;

  typedef enum logic {
    IDLE     = 1'b0,
    ASSEMBLE = 1'b1
  } cr_state_t;

  // One-hot of a 2-bit value, used for the characteristic strobes.
  function automatic logic [3:0] onehot4(input logic [1:0] v);
    logic [3:0] r;
    r    = '0;
    r[v] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/command_register_if.sv
// Bit-time control, serial command input and decoded command outputs
// exchanged between the control gate and the command register.
interface command_register_if;

  logic       RC;
  logic       T1;
  logic       T29;
  logic       CI;
  logic       CMD_BIT;
  logic       PWR_CLEAR;

  logic       CMD_LOAD;
  logic       CMD_DP;
  logic [4:0] CMD_D;
  logic [4:0] CMD_S;
  logic [1:0] CMD_C;
  logic [6:0] CMD_N;
  logic       CMD_BP;
  logic [6:0] CMD_T;
  logic       CMD_ID;
  logic       D6, D7, DX, DS;
  logic       S4, S5, S6, S7;
  logic       SU, SV, SW, SX;
  logic       CIR_1, CIR_2, CIR_3, CIR_4;

  modport master (
    output RC, T1, T29, CI, CMD_BIT, PWR_CLEAR,
    input  CMD_LOAD, CMD_DP, CMD_D, CMD_S, CMD_C, CMD_N, CMD_BP, CMD_T, CMD_ID,
    input  D6, D7, DX, DS, S4, S5, S6, S7, SU, SV, SW, SX,
    input  CIR_1, CIR_2, CIR_3, CIR_4
  );

  modport slave (
    input  RC, T1, T29, CI, CMD_BIT, PWR_CLEAR,
    output CMD_LOAD, CMD_DP, CMD_D, CMD_S, CMD_C, CMD_N, CMD_BP, CMD_T, CMD_ID,
    output D6, D7, DX, DS, S4, S5, S6, S7, SU, SV, SW, SX,
    output CIR_1, CIR_2, CIR_3, CIR_4
  );

endinterface

// File: rtl/command_register_field_decode.sv
// Splits a 5-bit D or S field into a one-hot of its upper three bits
// (group) and a one-hot of its lower two bits (member).
module cmd_field_decode (
  input  logic [4:0] field,
  output logic [7:0] hi_oh,
  output logic [3:0] lo_oh
);

  // Both one-hots follow the field combinationally.
  always_comb begin
    hi_oh             = '0;
    lo_oh             = '0;
    hi_oh[field[4:2]] = 1'b1;
    lo_oh[field[1:0]] = 1'b1;
  end

endmodule

// File: rtl/command_register.sv
// Serial-to-parallel command register. Assembles a 29-bit command
// LSB-first during RC, commits it at T29 and presents decoded strobes
// that stay frozen until the next successful commit.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   IDLE     | waiting for RC & T1 to start a word
//   ASSEMBLE | shifting bits 2..28 in; T29 commits if 28 bits were seen
module command_register
  import g15_pkg::*;
(
  input  logic CLOCK,
  input  logic rst,
  command_register_if.slave bus
);

  localparam logic [4:0] CNT_FULL = 5'(SHIFT_BITS);
  localparam logic [4:0] CNT_MAX  = 5'd31;

  cr_state_t          state, state_nxt;
  logic [4:0]         bit_cnt;
  logic [SHIFT_BITS-1:0] shift_q;
  cmd_word_t          hold_q;
  logic               load_q;

  logic               cap_bit;
  logic               do_start;
  logic               do_shift;
  logic               do_commit;

  assign cap_bit = bus.CMD_BIT & bus.CI;

  // State register; power clear parks the FSM like a reset.
  always_ff @(posedge CLOCK) begin
    if (rst || bus.PWR_CLEAR) state <= IDLE;
    else                      state <= state_nxt;
  end

  // Next state: dropping RC aborts, T1 restarts, T29 always ends the word.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.RC && bus.T1) state_nxt = ASSEMBLE;
      end
      ASSEMBLE: begin
        if (!bus.RC)     state_nxt = IDLE;
        else if (bus.T1) state_nxt = ASSEMBLE;
        else if (bus.T29) state_nxt = IDLE;
        else             state_nxt = ASSEMBLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath strobes; a T29 on a misaligned word ends it without a commit.
  always_comb begin
    do_start  = 1'b0;
    do_shift  = 1'b0;
    do_commit = 1'b0;
    case (state)
      IDLE: begin
        if (bus.RC && bus.T1) do_start = 1'b1;
      end
      ASSEMBLE: begin
        if (bus.RC) begin
          if (bus.T1)       do_start  = 1'b1;
          else if (bus.T29) do_commit = (bit_cnt == CNT_FULL);
          else              do_shift  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Shift register and bit counter; new bits enter at the top so bit 1
  // ends up in the LSB after 28 shifts.
  always_ff @(posedge CLOCK) begin
    if (rst || bus.PWR_CLEAR) begin
      shift_q <= '0;
      bit_cnt <= '0;
    end else if (do_start) begin
      shift_q <= {cap_bit, shift_q[SHIFT_BITS-1:1]};
      bit_cnt <= 5'd1;
    end else if (do_shift) begin
      shift_q <= {cap_bit, shift_q[SHIFT_BITS-1:1]};
      if (bit_cnt != CNT_MAX) bit_cnt <= bit_cnt + 5'd1;
    end
  end

  // Holding register and load pulse; bit 29 bypasses the shift register.
  always_ff @(posedge CLOCK) begin
    if (rst || bus.PWR_CLEAR) begin
      hold_q <= '0;
      load_q <= 1'b0;
    end else begin
      load_q <= do_commit;
      if (do_commit) hold_q <= cmd_word_t'({cap_bit, shift_q});
    end
  end

  logic [7:0] d_hi, s_hi;
  logic [3:0] d_lo, s_lo;

  cmd_field_decode u_dec_d (
    .field (hold_q.d),
    .hi_oh (d_hi),
    .lo_oh (d_lo)
  );

  cmd_field_decode u_dec_s (
    .field (hold_q.s),
    .hi_oh (s_hi),
    .lo_oh (s_lo)
  );

  // Only the D groups 6/7 and member 3 are meaningful to the control gate.
  logic d_unused;
  assign d_unused = ^{d_hi[5:0], d_lo[2:0]};

  logic [3:0] cir_oh;
  assign cir_oh = onehot4(hold_q.c);

  assign bus.CMD_LOAD = load_q;
  assign bus.CMD_DP   = hold_q.dp;
  assign bus.CMD_D    = hold_q.d;
  assign bus.CMD_S    = hold_q.s;
  assign bus.CMD_C    = hold_q.c;
  assign bus.CMD_N    = hold_q.n;
  assign bus.CMD_BP   = hold_q.bp;
  assign bus.CMD_T    = hold_q.t;
  assign bus.CMD_ID   = hold_q.id;

  assign bus.D6 = d_hi[6];
  assign bus.D7 = d_hi[7];
  assign bus.DX = d_lo[3];
  assign bus.DS = d_hi[7] & d_lo[3];

  assign bus.S4 = s_hi[4];
  assign bus.S5 = s_hi[5];
  assign bus.S6 = s_hi[6];
  assign bus.S7 = s_hi[7];
  assign bus.SU = s_lo[0];
  assign bus.SV = s_lo[1];
  assign bus.SW = s_lo[2];
  assign bus.SX = s_lo[3];

  assign bus.CIR_1 = cir_oh[0];
  assign bus.CIR_2 = cir_oh[1];
  assign bus.CIR_3 = cir_oh[2];
  assign bus.CIR_4 = cir_oh[3];

endmodule

// File: tb/tb_command_register.sv
// Scoreboard bench for command_register: each word expected to commit is
// queued before it is sent; a monitor pops and checks on every CMD_LOAD.
module tb_command_register;
  import g15_pkg::*;

  logic CLOCK = 1'b0;
  logic rst;

  always #5 CLOCK = ~CLOCK;

  command_register_if bus ();

  command_register dut (
    .CLOCK (CLOCK),
    .rst   (rst),
    .bus   (bus)
  );

  typedef struct {
    logic [28:0] word;
    logic [15:0] dec;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Decode vector order: DS D6 D7 DX | S4 S5 S6 S7 | SU SV SW SX | CIR_1..4
  localparam logic [15:0] DEC_ZERO = 16'b0000_0000_1000_1000;
  localparam logic [15:0] DEC_A    = 16'b1011_1000_1000_1000; // D=31 S=16 C=0
  localparam logic [15:0] DEC_B    = 16'b0101_0001_0100_0010; // D=27 S=29 C=2

  function automatic logic [28:0] mk(input logic dp, input logic [4:0] d,
                                     input logic [4:0] s, input logic [1:0] c,
                                     input logic [6:0] n, input logic bp,
                                     input logic [6:0] t, input logic id);
    return {id, t, bp, n, c, s, d, dp};
  endfunction

  logic [28:0] word_a, word_b, word_z;

  function automatic logic [28:0] act_word();
    return {bus.CMD_ID, bus.CMD_T, bus.CMD_BP, bus.CMD_N, bus.CMD_C,
            bus.CMD_S, bus.CMD_D, bus.CMD_DP};
  endfunction

  function automatic logic [15:0] act_dec();
    return {bus.DS, bus.D6, bus.D7, bus.DX, bus.S4, bus.S5, bus.S6, bus.S7,
            bus.SU, bus.SV, bus.SW, bus.SX,
            bus.CIR_1, bus.CIR_2, bus.CIR_3, bus.CIR_4};
  endfunction

  // Monitor: every load pulse must match the oldest queued expectation.
  always @(negedge CLOCK) begin
    if (bus.CMD_LOAD === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_load: CMD_LOAD=1 word=%h, required no load", act_word());
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        n_tests++;
        if (act_word() !== e.word) begin
          n_fail++;
          $display("FAIL %s_word: got %h, required %h", e.name, act_word(), e.word);
        end
        n_tests++;
        if (act_dec() !== e.dec) begin
          n_fail++;
          $display("FAIL %s_dec: got %b, required %b", e.name, act_dec(), e.dec);
        end
      end
    end
  end

  task automatic expect_load(input logic [28:0] w, input logic [15:0] d, input string nm);
    exp_t e;
    e.word = w;
    e.dec  = d;
    e.name = nm;
    sb_q.push_back(e);
  endtask

  task automatic drive(input logic rc, input logic t1, input logic t29,
                       input logic b, input logic ci, input logic pc);
    bus.RC        = rc;
    bus.T1        = t1;
    bus.T29       = t29;
    bus.CMD_BIT   = b;
    bus.CI        = ci;
    bus.PWR_CLEAR = pc;
    @(posedge CLOCK);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  // Sends bits first..last of a word under RC, then one idle cycle.
  task automatic send_word(input logic [28:0] w, input logic ci,
                           input int first, input int last, input logic pc_last);
    for (int i = first; i <= last; i++)
      drive(1'b1, i == 1, i == 29, w[i-1], ci, (i == 29) && pc_last);
    idle(1);
  endtask

  // Static check of the holding outputs while no load is pending.
  task automatic check_hold(input logic [28:0] w, input logic [15:0] d, input string nm);
    @(negedge CLOCK);
    n_tests++;
    if (act_word() !== w) begin
      n_fail++;
      $display("FAIL %s_hold_word: got %h, required %h", nm, act_word(), w);
    end
    n_tests++;
    if (act_dec() !== d) begin
      n_fail++;
      $display("FAIL %s_hold_dec: got %b, required %b", nm, act_dec(), d);
    end
    n_tests++;
    if (bus.CMD_LOAD !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_load_idle: got %b, required 0", nm, bus.CMD_LOAD);
    end
  endtask

  initial begin
    word_a = mk(1'b0, 5'd31, 5'd16, 2'd0, 7'h05, 1'b0, 7'h10, 1'b1);
    word_b = mk(1'b1, 5'd27, 5'd29, 2'd2, 7'h2A, 1'b1, 7'h33, 1'b0);
    word_z = '0;

    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(4);
    check_hold(word_z, DEC_ZERO, "reset");

    expect_load(word_a, DEC_A, "word_a");
    send_word(word_a, 1'b1, 1, 29, 1'b0);
    check_hold(word_a, DEC_A, "after_a");

    expect_load(word_z, DEC_ZERO, "ci_zero");
    send_word(word_a, 1'b0, 1, 29, 1'b0);
    check_hold(word_z, DEC_ZERO, "after_ci_zero");

    expect_load(word_b, DEC_B, "word_b");
    send_word(word_b, 1'b1, 1, 29, 1'b0);
    send_word(word_a, 1'b1, 1, 14, 1'b0);
    check_hold(word_b, DEC_B, "abort");

    send_word(word_a, 1'b1, 5, 29, 1'b0);
    check_hold(word_b, DEC_B, "misaligned");

    for (int i = 1; i <= 10; i++) drive(1'b1, i == 1, 1'b0, word_b[i-1], 1'b1, 1'b0);
    expect_load(word_a, DEC_A, "restart");
    send_word(word_a, 1'b1, 1, 29, 1'b0);
    check_hold(word_a, DEC_A, "after_restart");

    send_word(word_b, 1'b1, 1, 29, 1'b1);
    check_hold(word_z, DEC_ZERO, "pwr_clear");

    expect_load(word_b, DEC_B, "pre_rst");
    send_word(word_b, 1'b1, 1, 29, 1'b0);
    for (int i = 1; i <= 19; i++) drive(1'b1, i == 1, 1'b0, word_a[i-1], 1'b1, 1'b0);
    rst = 1'b1;
    drive(1'b1, 1'b0, 1'b0, word_a[19], 1'b1, 1'b0);
    rst = 1'b0;
    idle(2);
    check_hold(word_z, DEC_ZERO, "mid_rst");
    expect_load(word_a, DEC_A, "post_rst");
    send_word(word_a, 1'b1, 1, 29, 1'b0);
    check_hold(word_a, DEC_A, "after_post_rst");

    idle(5);
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL missing_load: %0d expected loads pending, required 0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
